// File: rtl/alu_pkg.sv
// Shared types for the digit-serial NEG/SUB/ADD/ONES unit: op encoding, flag bundle, FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NEG  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADD  = 2'b10,
    OP_ONES = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/sub_digit_slice.sv
// DIGIT-bit ripple slice with carry in/out; the serial unit reuses it once per cycle.
module sub_digit_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  end

endmodule

// File: rtl/alu_serial_sub.sv
// Digit-serial NEG/SUB/ADD/ONES, one DIGIT slice per cycle, LSB first.
// Define ALU_SERIAL_SUB_SATURATE_EN to clamp overflowed results to signed max/min.
module alu_serial_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("alu_serial_sub: WIDTH must be a multiple of DIGIT");
  end

  alu_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  alu_op_e           op_q, op_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  alu_flags_t        flags_q, flags_d;

  logic [WIDTH-1:0]  x_full, y_full, final_res;
  logic [DIGIT-1:0]  x_sl, y_sl, sum;
  logic              cin, cout, ovf;

  // NEG is 0 + ~a + 1, SUB is a + ~b + 1; ONES reuses the NEG path without the carry.
  always_comb begin
    x_full = '0;
    y_full = ~a_q;
    case (op_q)
      OP_SUB:  begin x_full = a_q; y_full = ~b_q; end
      OP_ADD:  begin x_full = a_q; y_full = b_q;  end
      default: begin x_full = '0;  y_full = ~a_q; end
    endcase
    x_sl = x_full[idx_q*DIGIT +: DIGIT];
    y_sl = y_full[idx_q*DIGIT +: DIGIT];
    if (op_q == OP_ONES)
      cin = 1'b0;
    else if (idx_q == '0)
      cin = (op_q == OP_NEG) || (op_q == OP_SUB);
    else
      cin = carry_q;
  end

  sub_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (x_sl),
    .y    (y_sl),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // acc shifts right so the final slice lands at the top after N cycles.
  always_comb begin
    acc_d = (acc_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
    ovf   = (op_q != OP_ONES) && (x_full[WIDTH-1] == y_full[WIDTH-1]) &&
            (acc_d[WIDTH-1] != x_full[WIDTH-1]);
`ifdef ALU_SERIAL_SUB_SATURATE_EN
    // On overflow the true sign is the shared operand sign.
    final_res = ovf ? (x_full[WIDTH-1] ? SMIN : SMAX) : acc_d;
`else
    final_res = acc_d;
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = alu_op_e'(op);
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        carry_d = cout;
        if (idx_q == IW'(N - 1)) begin
          idx_d      = '0;
          state_d    = ST_DONE;
          result_d   = final_res;
          flags_d.zf = (final_res == '0);
          flags_d.sf = final_res[WIDTH-1];
          flags_d.of = ovf;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NEG;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= (state_q == ST_BUSY) ? acc_d : acc_q;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zf        = flags_q.zf;
  assign sf        = flags_q.sf;
  assign of        = flags_q.of;

endmodule

// File: tb/tb_alu_serial_sub.sv
// Directed-vector bench for alu_serial_sub (WIDTH=64, DIGIT=8).
module tb_alu_serial_sub;

  localparam int W = 64;
  localparam int N = 8;
  localparam logic [W-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] SMIN = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zf, sf, of;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_serial_sub #(.WIDTH(W), .DIGIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operation and step through the N busy cycles, checking latency.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit noise);
    check({tag, ".in_ready"}, W'(in_ready), 1);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (noise && k < N) begin
        in_valid = 1'b1; op = 2'b10; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (k == N - 1) begin
        check({tag, ".early_valid"}, W'(out_valid), 0);
        check({tag, ".busy_ready"}, W'(in_ready), 0);
      end
    end
    check({tag, ".latency"}, W'(out_valid), 1);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r,
                            input logic ezf, input logic esf, input logic eof);
    check({tag, ".result"}, result, r);
    check({tag, ".flags"}, W'({zf, sf, of}), W'({ezf, esf, eof}));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".idle"}, W'({in_ready, out_valid}), W'(2'b10));
  endtask

  initial begin
    int stray;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.hs", W'({in_ready, out_valid}), W'(2'b10));
    check("reset.result", result, '0);
    check("reset.flags", W'({zf, sf, of}), '0);

    run_op("neg_m1", 2'b00, '1, '0, 0);
    expect_out("neg_m1", 64'd1, 0, 0, 0);
    release_out("neg_m1");

    run_op("neg_m100", 2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'h1234, 1);
    expect_out("neg_m100", 64'd100, 0, 0, 0);
    release_out("neg_m100");

    run_op("neg_123456", 2'b00, 64'h1E240, '0, 0);
    expect_out("neg_123456", 64'hFFFF_FFFF_FFFE_1DC0, 0, 1, 0);
    release_out("neg_123456");

    run_op("neg_min", 2'b00, SMIN, '0, 0);
`ifdef ALU_SERIAL_SUB_SATURATE_EN
    expect_out("neg_min", SMAX, 0, 0, 1);
`else
    expect_out("neg_min", SMIN, 0, 1, 1);
`endif
    release_out("neg_min");

    // SUB 5-5 held in DONE; a new request offered on the release edge must not be taken.
    run_op("sub_eq", 2'b01, 64'd5, 64'd5, 0);
    for (int k = 0; k < 3; k++) begin
      expect_out("sub_eq.hold", '0, 1, 0, 0);
      check("sub_eq.hold_valid", W'(out_valid), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; op = 2'b10; a = 64'd9; b = 64'd9;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("sub_eq.no_accept", W'({in_ready, out_valid}), W'(2'b10));

    run_op("add_max1", 2'b10, SMAX, 64'd1, 0);
`ifdef ALU_SERIAL_SUB_SATURATE_EN
    expect_out("add_max1", SMAX, 0, 0, 1);
`else
    expect_out("add_max1", SMIN, 0, 1, 1);
`endif
    release_out("add_max1");

    run_op("add_minm1", 2'b10, SMIN, '1, 0);
`ifdef ALU_SERIAL_SUB_SATURATE_EN
    expect_out("add_minm1", SMIN, 0, 1, 1);
`else
    expect_out("add_minm1", SMAX, 0, 0, 1);
`endif
    release_out("add_minm1");

    run_op("sub_min1", 2'b01, SMIN, 64'd1, 1);
`ifdef ALU_SERIAL_SUB_SATURATE_EN
    expect_out("sub_min1", SMIN, 0, 1, 1);
`else
    expect_out("sub_min1", SMAX, 0, 0, 1);
`endif
    release_out("sub_min1");

    run_op("sub_neg", 2'b01, 64'd3, 64'd10, 0);
    expect_out("sub_neg", 64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 0);
    release_out("sub_neg");

    run_op("add_carry", 2'b10, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0);
    expect_out("add_carry", 64'h2222_2222_2222_2211, 0, 0, 0);
    release_out("add_carry");

    run_op("ones", 2'b11, 64'h0F0F_0000_FFFF_8001, 64'hFFFF, 0);
    expect_out("ones", 64'hF0F0_FFFF_0000_7FFE, 0, 1, 0);
    release_out("ones");

    run_op("ones_m1", 2'b11, '1, '0, 0);
    expect_out("ones_m1", '0, 1, 0, 0);
    release_out("ones_m1");

    // Abort in the 4th busy cycle; nothing may be presented for the aborted op.
    in_valid = 1'b1; op = 2'b00; a = 64'd5; b = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.hs", W'({in_ready, out_valid}), W'(2'b10));
    check("abort.result", result, '0);
    stray = 0;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("abort.stray_valid", W'(stray), 0);

    run_op("neg_2", 2'b00, 64'd2, '0, 0);
    expect_out("neg_2", 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0);
    release_out("neg_2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
